lif_neuron: RTL and testbench

Leaky integrate-and-fire neuron that consumes the per-cycle spike stream produced by the Poisson spike encoder and integrates weighted input spikes into a signed membrane potential. It applies a shift-based leak, fires when the potential crosses a threshold, then holds a refractory period. It sits directly downstream of the encoder, one instance per encoder/synapse pair, and feeds the output-layer spike counters.

---
 rtl/snn_pkg.sv | 23 ++
 rtl/lif_sat_add.sv | 39 +++
 rtl/lif_neuron.sv | 130 +++++++++++++
 tb/tb_lif_neuron.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/snn_pkg.sv
// Shared definitions for the spiking neuron blocks: LIF state encoding and
// signed range helpers used when reducing a widened sum back to WIDTH bits.
package snn_pkg;

  typedef enum logic {
    ST_INTEGRATE = 1'b0,
    ST_REFRACT   = 1'b1
  } lif_state_e;

  // Extra headroom bits carried by the membrane update sum.
  localparam int SUM_GUARD_BITS = 2;

  // Largest signed value representable in w bits.
  function automatic longint signed_max(input int w);
    return (longint'(1) <<< (w - 1)) - longint'(1);
  endfunction

  // Smallest signed value representable in w bits.
  function automatic longint signed_min(input int w);
    return -(longint'(1) <<< (w - 1));
  endfunction

endpackage

// File: rtl/lif_sat_add.sv
// Reduces the WIDTH+2 bit membrane update sum to WIDTH bits.
// Build option LIF_SATURATE_EN: clamp to the signed WIDTH range; otherwise the
// sum wraps (low WIDTH bits kept, two's-complement).
module lif_sat_add
  import snn_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH+SUM_GUARD_BITS-1:0] sum_in,
  output logic [WIDTH-1:0]                sum_out
);

  localparam int SW = WIDTH + SUM_GUARD_BITS;

`ifdef LIF_SATURATE_EN
  localparam logic signed [SW-1:0] MAX_V = SW'(signed_max(WIDTH));
  localparam logic signed [SW-1:0] MIN_V = SW'(signed_min(WIDTH));

  // Clamp anything outside the signed WIDTH range to the nearest limit.
  always_comb begin
    sum_out = sum_in[WIDTH-1:0];
    if ($signed(sum_in) > MAX_V) begin
      sum_out = MAX_V[WIDTH-1:0];
    end else if ($signed(sum_in) < MIN_V) begin
      sum_out = MIN_V[WIDTH-1:0];
    end
  end
`else
  // Guard bits are simply discarded in wrap mode.
  logic [SUM_GUARD_BITS-1:0] unused_guard;
  assign unused_guard = sum_in[SW-1:WIDTH];

  // Keep the low WIDTH bits (two's-complement wrap).
  always_comb begin
    sum_out = sum_in[WIDTH-1:0];
  end
`endif

endmodule

// File: rtl/lif_neuron.sv
// Leaky integrate-and-fire neuron: integrates weighted input spikes with a
// shift-based leak, fires at THRESHOLD, then holds a refractory period.
// Build option LIF_SATURATE_EN selects clamping (vs wrapping) of the update sum.
// Handshake: none. spike_in/weight are sampled on every enabled rising edge;
// results appear on the registered outputs one cycle later. en=0 freezes all
// state and forces spike_out low.
module lif_neuron
  import snn_pkg::*;
#(
  parameter int WIDTH             = 16,
  parameter int THRESHOLD         = 100,
  parameter int LEAK_SHIFT        = 4,
  parameter int REFRACTORY_CYCLES = 2,
  parameter int CNT_WIDTH         = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 spike_in,
  input  logic [WIDTH-1:0]     weight,
  output logic                 spike_out,
  output logic [WIDTH-1:0]     membrane,
  output logic                 refractory,
  output logic [CNT_WIDTH-1:0] spike_count,
  output logic                 state_dbg
);

  localparam int SW   = WIDTH + SUM_GUARD_BITS;
  localparam int RC_W = (REFRACTORY_CYCLES > 1) ? $clog2(REFRACTORY_CYCLES + 1) : 1;
  localparam logic signed [WIDTH-1:0] THR = WIDTH'(THRESHOLD);

  lif_state_e state_q, state_d;
  logic signed [WIDTH-1:0] membrane_q, membrane_d;
  logic                    spike_out_q, spike_out_d;
  logic [CNT_WIDTH-1:0]    count_q, count_d;
  logic [RC_W-1:0]         rc_q, rc_d;

  logic signed [WIDTH-1:0] leak;
  logic [WIDTH-1:0]        addend;
  logic [SW-1:0]           sum_wide;
  logic [WIDTH-1:0]        sum_red;
  logic                    fire;

  // Membrane update: v - (v >>> LEAK_SHIFT) + weighted spike, at WIDTH+2 bits.
  always_comb begin
    leak     = membrane_q >>> LEAK_SHIFT;
    addend   = spike_in ? weight : '0;
    sum_wide = {{SUM_GUARD_BITS{membrane_q[WIDTH-1]}}, membrane_q}
             - {{SUM_GUARD_BITS{leak[WIDTH-1]}}, leak}
             + {{SUM_GUARD_BITS{addend[WIDTH-1]}}, addend};
    fire     = ($signed(sum_red) >= THR);
  end

  lif_sat_add #(
    .WIDTH (WIDTH)
  ) u_sat_add (
    .sum_in  (sum_wide),
    .sum_out (sum_red)
  );

  // State register; reset beats enable and any pending refractory count.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_INTEGRATE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: enter REFRACT on a fire, leave when the counter is on its last cycle.
  always_comb begin
    state_d = state_q;
    if (en) begin
      case (state_q)
        ST_INTEGRATE: if (fire && (REFRACTORY_CYCLES > 0)) state_d = ST_REFRACT;
        ST_REFRACT:   if (rc_q == RC_W'(1)) state_d = ST_INTEGRATE;
        default:      state_d = ST_INTEGRATE;
      endcase
    end
  end

  // Datapath next values: membrane, fire pulse, fire count, refractory counter.
  always_comb begin
    membrane_d  = membrane_q;
    spike_out_d = 1'b0;
    count_d     = count_q;
    rc_d        = rc_q;
    if (en) begin
      case (state_q)
        ST_INTEGRATE: begin
          if (fire) begin
            membrane_d  = '0;
            spike_out_d = 1'b1;
            rc_d        = RC_W'(REFRACTORY_CYCLES);
            if (count_q != {CNT_WIDTH{1'b1}}) count_d = count_q + CNT_WIDTH'(1);
          end else begin
            membrane_d = $signed(sum_red);
          end
        end
        ST_REFRACT: begin
          membrane_d = '0;
          rc_d       = rc_q - RC_W'(1);
        end
        default: membrane_d = '0;
      endcase
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      membrane_q  <= '0;
      spike_out_q <= 1'b0;
      count_q     <= '0;
      rc_q        <= '0;
    end else begin
      membrane_q  <= membrane_d;
      spike_out_q <= spike_out_d;
      count_q     <= count_d;
      rc_q        <= rc_d;
    end
  end

  assign spike_out   = spike_out_q;
  assign membrane    = membrane_q;
  assign refractory  = (state_q == ST_REFRACT);
  assign spike_count = count_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_lif_neuron.sv
// Self-checking bench for lif_neuron: three instances (defaults, THRESHOLD=32767,
// CNT_WIDTH=2 with no refractory), a directed vector table, hand sequences for
// saturation/wrap and counter saturation, then randomized checks against a model.
module tb_lif_neuron;

  localparam int EW = 34;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_i [3];
  logic        en_i  [3];
  logic        spk_i [3];
  logic [15:0] w_i   [3];

  logic        so0, so1, so2, rf0, rf1, rf2, dbg0, dbg1, dbg2;
  logic [15:0] mem0, mem1, mem2, cnt0, cnt1;
  logic [1:0]  cnt2;

  lif_neuron u_dut (
    .clk(clk), .rst(rst_i[0]), .en(en_i[0]), .spike_in(spk_i[0]), .weight(w_i[0]),
    .spike_out(so0), .membrane(mem0), .refractory(rf0), .spike_count(cnt0), .state_dbg(dbg0)
  );

  lif_neuron #(.THRESHOLD(32767)) u_sat (
    .clk(clk), .rst(rst_i[1]), .en(en_i[1]), .spike_in(spk_i[1]), .weight(w_i[1]),
    .spike_out(so1), .membrane(mem1), .refractory(rf1), .spike_count(cnt1), .state_dbg(dbg1)
  );

  lif_neuron #(.CNT_WIDTH(2), .REFRACTORY_CYCLES(0)) u_cnt (
    .clk(clk), .rst(rst_i[2]), .en(en_i[2]), .spike_in(spk_i[2]), .weight(w_i[2]),
    .spike_out(so2), .membrane(mem2), .refractory(rf2), .spike_count(cnt2), .state_dbg(dbg2)
  );

  // ---------------- reference model ----------------
  typedef struct {
    int v;
    int refr_left;
    int cnt;
    bit spk;
  } model_t;

  model_t mdl [3];
  int thr_k  [3] = '{100, 32767, 100};
  int rc_k   [3] = '{2, 2, 0};
  int cmax_k [3] = '{65535, 65535, 3};

  function automatic int reduce16(input int s);
    int t;
`ifdef LIF_SATURATE_EN
    t = s;
    if (s > 32767) t = 32767;
    if (s < -32768) t = -32768;
`else
    t = s & 32'hFFFF;
    if (t >= 32768) t = t - 65536;
`endif
    return t;
  endfunction

  function automatic model_t mstep(input model_t m, input bit r, input bit e, input bit s,
                                   input int w, input int thr, input int rc, input int cmax);
    model_t n;
    int sum;
    n = m;
    n.spk = 1'b0;
    if (!r) begin
      n.v = 0; n.refr_left = 0; n.cnt = 0;
    end else if (e) begin
      if (m.refr_left > 0) begin
        n.refr_left = m.refr_left - 1;
        n.v = 0;
      end else begin
        sum = reduce16(m.v - (m.v >>> 4) + (s ? w : 0));
        if (sum >= thr) begin
          n.v = 0;
          n.spk = 1'b1;
          n.refr_left = rc;
          if (m.cnt < cmax) n.cnt = m.cnt + 1;
        end else begin
          n.v = sum;
        end
      end
    end
    return n;
  endfunction

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [EW-1:0] exp_q [$];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic sample(input int k, output int mem, output int so, output int rf, output int cnt);
    case (k)
      0:       begin mem = int'($signed(mem0)); so = int'(so0); rf = int'(rf0); cnt = int'(cnt0); end
      1:       begin mem = int'($signed(mem1)); so = int'(so1); rf = int'(rf1); cnt = int'(cnt1); end
      default: begin mem = int'($signed(mem2)); so = int'(so2); rf = int'(rf2); cnt = int'(cnt2); end
    endcase
  endtask

  task automatic chk_dut(input int k, input string tag, input int e_mem, input int e_so,
                         input int e_rf, input int e_cnt);
    int mem, so, rf, cnt;
    sample(k, mem, so, rf, cnt);
    check($sformatf("%s membrane", tag), mem, e_mem);
    check($sformatf("%s spike_out", tag), so, e_so);
    check($sformatf("%s refractory", tag), rf, e_rf);
    check($sformatf("%s spike_count", tag), cnt, e_cnt);
  endtask

  // ---------------- driver ----------------
  task automatic drive(input int k, input bit r, input bit e, input bit s, input int w);
    rst_i[k] = r;
    en_i[k]  = e;
    spk_i[k] = s;
    w_i[k]   = 16'(w);
  endtask

  // One clock: advance the models with the applied inputs, return at negedge.
  task automatic cycle();
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      mdl[k] = mstep(mdl[k], rst_i[k], en_i[k], spk_i[k], int'($signed(w_i[k])),
                     thr_k[k], rc_k[k], cmax_k[k]);
    end
    @(negedge clk);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit r; bit e; bit s; int w;
    int mem; int so; int rf; int cnt;
  } vec_t;

  vec_t vecs [$];

  task automatic add_vec(input bit r, input bit e, input bit s, input int w,
                         input int mem, input int so, input int rf, input int cnt);
    vec_t v;
    v.r = r; v.e = e; v.s = s; v.w = w;
    v.mem = mem; v.so = so; v.rf = rf; v.cnt = cnt;
    vecs.push_back(v);
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      mdl[k].v = 0; mdl[k].refr_left = 0; mdl[k].cnt = 0; mdl[k].spk = 1'b0;
      drive(k, 1'b0, 1'b1, 1'b0, 0);
    end
    cycle();
    cycle();
    for (int k = 0; k < 3; k++) chk_dut(k, $sformatf("reset%0d", k), 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) drive(k, 1'b1, 1'b0, 1'b0, 0);

    //      r  e  s  w     mem  so rf cnt
    add_vec(0, 1, 0, 0,      0, 0, 0, 0);
    add_vec(1, 1, 1, 30,    30, 0, 0, 0);
    add_vec(1, 1, 1, 30,    59, 0, 0, 0);
    add_vec(1, 1, 1, 30,    86, 0, 0, 0);
    add_vec(1, 1, 0, 30,    81, 0, 0, 0);   // leak only
    add_vec(1, 1, 0, 30,    76, 0, 0, 0);
    add_vec(1, 1, 0, 30,    72, 0, 0, 0);
    add_vec(0, 1, 0, 0,      0, 0, 0, 0);
    add_vec(1, 1, 1, 30,    30, 0, 0, 0);
    add_vec(1, 1, 1, 30,    59, 0, 0, 0);
    add_vec(1, 1, 1, 30,    86, 0, 0, 0);
    add_vec(1, 1, 1, 30,     0, 1, 1, 1);   // fire on 4th spike
    add_vec(1, 1, 1, 30,     0, 0, 1, 1);   // spike ignored in REFRACT
    add_vec(1, 1, 1, 30,     0, 0, 0, 1);   // still ignored, refractory falls
    add_vec(1, 1, 1, 30,    30, 0, 0, 1);   // first accepted spike
    add_vec(1, 0, 1, 30,    30, 0, 0, 1);   // en low freezes
    add_vec(1, 0, 1, 30,    30, 0, 0, 1);
    add_vec(1, 0, 1, 30,    30, 0, 0, 1);
    add_vec(1, 1, 1, 30,    59, 0, 0, 1);
    add_vec(1, 1, 1, 30,    86, 0, 0, 1);
    add_vec(1, 1, 1, 30,     0, 1, 1, 2);
    add_vec(0, 1, 1, 30,     0, 0, 0, 0);   // reset in first REFRACT cycle
    add_vec(1, 1, 1, 30,    30, 0, 0, 0);   // back in INTEGRATE
    add_vec(1, 1, 1, -50,  -21, 0, 0, 0);   // negative potential
    add_vec(1, 1, 0, 0,    -19, 0, 0, 0);   // leak toward zero
    add_vec(1, 1, 0, 0,    -17, 0, 0, 0);
    add_vec(0, 1, 0, 0,      0, 0, 0, 0);
    add_vec(1, 1, 1, 30,    30, 0, 0, 0);
    add_vec(1, 1, 1, 30,    59, 0, 0, 0);
    add_vec(1, 1, 1, 30,    86, 0, 0, 0);
    add_vec(1, 1, 1, 30,     0, 1, 1, 1);
    add_vec(1, 0, 1, 30,     0, 0, 1, 1);   // en low kills the pulse, REFRACT held
    add_vec(1, 1, 1, 30,     0, 0, 1, 1);
    add_vec(1, 1, 1, 30,     0, 0, 0, 1);
    add_vec(1, 1, 1, 30,    30, 0, 0, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(0, vecs[i].r, vecs[i].e, vecs[i].s, vecs[i].w);
      cycle();
      chk_dut(0, $sformatf("vec%0d", i), vecs[i].mem, vecs[i].so, vecs[i].rf, vecs[i].cnt);
    end
    drive(0, 1'b1, 1'b0, 1'b0, 0);

    // Saturate vs wrap at THRESHOLD=32767.
    drive(1, 1'b0, 1'b1, 1'b0, 0);
    cycle();
    drive(1, 1'b1, 1'b1, 1'b1, 30000);
    cycle();
    chk_dut(1, "big1", 30000, 0, 0, 0);
    cycle();
`ifdef LIF_SATURATE_EN
    chk_dut(1, "big2_sat", 0, 1, 1, 1);
`else
    chk_dut(1, "big2_wrap", -7411, 0, 0, 0);
`endif
    drive(1, 1'b1, 1'b0, 1'b0, 0);

    // Back-to-back fires with a 2-bit saturating counter.
    drive(2, 1'b0, 1'b1, 1'b0, 0);
    cycle();
    drive(2, 1'b1, 1'b1, 1'b1, 200);
    for (int i = 1; i <= 4; i++) begin
      cycle();
      chk_dut(2, $sformatf("cnt_fire%0d", i), 0, 1, 0, (i > 3) ? 3 : i);
    end
    drive(2, 1'b1, 1'b0, 1'b1, 200);
    cycle();
    chk_dut(2, "cnt_hold", 0, 0, 0, 3);

    // Randomized phase against the model.
    for (int k = 0; k < 3; k++) drive(k, 1'b0, 1'b1, 1'b0, 0);
    cycle();
    for (int n = 0; n < 1500; n++) begin
      drive(0, $urandom_range(0, 63) != 0, $urandom_range(0, 7) != 0, 1'($urandom_range(0, 1)),
            int'($urandom_range(0, 200)) - 60);
      drive(1, $urandom_range(0, 63) != 0, $urandom_range(0, 7) != 0, 1'($urandom_range(0, 1)),
            int'($urandom_range(0, 65535)) - 32768);
      drive(2, $urandom_range(0, 63) != 0, $urandom_range(0, 7) != 0, 1'($urandom_range(0, 1)),
            int'($urandom_range(0, 300)) - 100);
      cycle();
      for (int k = 0; k < 3; k++) begin
        exp_q.push_back({16'(mdl[k].v), mdl[k].spk, (mdl[k].refr_left > 0), 16'(mdl[k].cnt)});
      end
      for (int k = 0; k < 3; k++) begin
        logic [EW-1:0] e;
        e = exp_q.pop_front();
        chk_dut(k, $sformatf("rand%0d_dut%0d", n, k), int'($signed(e[33:18])), int'(e[17]),
                int'(e[16]), int'(e[15:0]));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
